// File: rtl/slow_window_ctl_pkg.sv
// Shared definitions for the slow-window controller and its bench.
package slow_window_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } slowState_t;

    localparam int unsigned TO_W_DEFAULT = 4;

    // Power-on timeout, also used by the config stage as its reset value.
    localparam logic [3:0] SLOW_TIMEOUT_RST = 4'h3;

endpackage

// File: rtl/slow_window_ctl_if.sv
// Bus-side access decode: access strobe plus per-class chip selects.
interface slow_window_ctl_if;

    logic BACT;
    logic IACKCS;
    logic VIACS;
    logic IWMCS;
    logic SCCCS;
    logic SCSICS;
    logic SndCS;

    modport master (
        output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS
    );

    modport slave (
        input BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS
    );

endinterface

// File: rtl/slow_window_ctl_qual.sv
// Class match: the current access hits a peripheral class marked slow.
module slow_qual (
    input  logic IACKCS,
    input  logic VIACS,
    input  logic IWMCS,
    input  logic SCCCS,
    input  logic SCSICS,
    input  logic SndCS,
    input  logic SlowIACK,
    input  logic SlowVIA,
    input  logic SlowIWM,
    input  logic SlowSCC,
    input  logic SlowSCSI,
    input  logic SlowSnd,
    output logic Qual
);

    // Any enabled class that the current access decodes to.
    always_comb begin
        Qual = (IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM) ||
               (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || (SndCS && SlowSnd);
    end

endmodule

// File: rtl/slow_window_ctl.sv
// Slow-window controller: opens a window on a qualifying bus access, holds it
// for SlowTimeout ticks after the access ends, and drives SlowReq/SlowGateReq.
// Optional debug window counter enabled by defining SLOW_WINDOW_DBG_EN.
module slow_window_ctl
    import slow_window_ctl_pkg::*;
#(
    parameter int unsigned TO_W  = TO_W_DEFAULT,
    parameter int unsigned DBG_W = 16
) (
    input  logic               CLK,
    input  logic               nPOR,
    slow_window_ctl_if.slave   bus,
    input  logic               SlowIACK,
    input  logic               SlowVIA,
    input  logic               SlowIWM,
    input  logic               SlowSCC,
    input  logic               SlowSCSI,
    input  logic               SlowSnd,
    input  logic               SlowClockGate,
    input  logic [TO_W-1:0]    SlowTimeout,
    input  logic               Tick,
    output logic               SlowReq,
    output logic               SlowGateReq,
    output logic [TO_W-1:0]    SlowCnt
`ifdef SLOW_WINDOW_DBG_EN
    ,
    output logic [DBG_W-1:0]   SlowWinCnt
`endif
);

    localparam logic [TO_W-1:0] CntOne = TO_W'(1);

    slowState_t      state, stateNext;
    logic [TO_W-1:0] cntNext;
    logic            bactR;
    logic            start;
    logic            qual;
    logic            reqNext;

    slow_qual uQual (
        .IACKCS   (bus.IACKCS),
        .VIACS    (bus.VIACS),
        .IWMCS    (bus.IWMCS),
        .SCCCS    (bus.SCCCS),
        .SCSICS   (bus.SCSICS),
        .SndCS    (bus.SndCS),
        .SlowIACK (SlowIACK),
        .SlowVIA  (SlowVIA),
        .SlowIWM  (SlowIWM),
        .SlowSCC  (SlowSCC),
        .SlowSCSI (SlowSCSI),
        .SlowSnd  (SlowSnd),
        .Qual     (qual)
    );

    assign start = bus.BACT && !bactR;

    // Next state and hold counter; a qualifying Start in HOLD beats a Tick.
    always_comb begin
        stateNext = state;
        cntNext   = SlowCnt;
        unique case (state)
            IDLE: begin
                if (start && qual) stateNext = ACTIVE;
            end
            ACTIVE: begin
                if (!bus.BACT) begin
                    if (SlowTimeout != '0) begin
                        stateNext = HOLD;
                        cntNext   = SlowTimeout;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            HOLD: begin
                if (start && qual) begin
                    stateNext = ACTIVE;
                end else if (Tick) begin
                    if (SlowCnt > CntOne) begin
                        cntNext = SlowCnt - CntOne;
                    end else begin
                        // Terminal tick; also recovers from a zero count.
                        stateNext = IDLE;
                        cntNext   = '0;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
        reqNext = (stateNext != IDLE);
    end

    // State, counter, registered outputs and the BACT edge detector.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state       <= IDLE;
            SlowReq     <= 1'b0;
            SlowGateReq <= 1'b0;
            SlowCnt     <= '0;
            bactR       <= 1'b0;
        end else begin
            state       <= stateNext;
            SlowReq     <= reqNext;
            SlowGateReq <= reqNext && SlowClockGate;
            SlowCnt     <= cntNext;
            bactR       <= bus.BACT;
        end
    end

`ifdef SLOW_WINDOW_DBG_EN
    localparam logic [DBG_W-1:0] WinMax = '1;

    // Count fresh windows only (IDLE -> ACTIVE), saturating.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            SlowWinCnt <= '0;
        end else if (state == IDLE && stateNext == ACTIVE && SlowWinCnt != WinMax) begin
            SlowWinCnt <= SlowWinCnt + DBG_W'(1);
        end
    end
`else
    logic unusedDbg;
    assign unusedDbg = (DBG_W != 0);
`endif

endmodule

// File: tb/tb_slow_window_ctl.sv
// Directed bench for slow_window_ctl.
module tb_slow_window_ctl;
    import slow_window_ctl_pkg::*;

    logic       CLK;
    logic       nPOR;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       Tick;
    logic       SlowReq;
    logic       SlowGateReq;
    logic [3:0] SlowCnt;
`ifdef SLOW_WINDOW_DBG_EN
    logic [15:0] SlowWinCnt;
`endif

    int passCnt  = 0;
    int totalCnt = 0;

    slow_window_ctl_if bus ();

    slow_window_ctl #(
        .TO_W  (4),
        .DBG_W (16)
    ) dut (
        .CLK           (CLK),
        .nPOR          (nPOR),
        .bus           (bus),
        .SlowIACK      (SlowIACK),
        .SlowVIA       (SlowVIA),
        .SlowIWM       (SlowIWM),
        .SlowSCC       (SlowSCC),
        .SlowSCSI      (SlowSCSI),
        .SlowSnd       (SlowSnd),
        .SlowClockGate (SlowClockGate),
        .SlowTimeout   (SlowTimeout),
        .Tick          (Tick),
        .SlowReq       (SlowReq),
        .SlowGateReq   (SlowGateReq),
        .SlowCnt       (SlowCnt)
`ifdef SLOW_WINDOW_DBG_EN
        ,
        .SlowWinCnt    (SlowWinCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; sampling happens 1 time unit after the edge.
    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearBus();
        bus.BACT = 0; bus.IACKCS = 0; bus.VIACS = 0; bus.IWMCS = 0;
        bus.SCCCS = 0; bus.SCSICS = 0; bus.SndCS = 0;
    endtask

    task automatic test_reset();
        nPOR = 0;
        clearBus();
        SlowIACK = 0; SlowVIA = 0; SlowIWM = 0; SlowSCC = 0; SlowSCSI = 0; SlowSnd = 0;
        SlowClockGate = 0; SlowTimeout = SLOW_TIMEOUT_RST; Tick = 0;
        #1;
        totalCnt++;
        if ({SlowReq, SlowGateReq, SlowCnt} !== 6'b0)
            $display("FAIL reset_init: got req=%b gate=%b cnt=%0d want 0/0/0",
                     SlowReq, SlowGateReq, SlowCnt);
        else passCnt++;
        clk1();
        nPOR = 1;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b0) $display("FAIL reset_idle: got req=%b want 0", SlowReq);
        else passCnt++;
    endtask

    task automatic test_via();
        SlowVIA = 1; SlowTimeout = 4'd3; SlowClockGate = 1;
        bus.BACT = 1; bus.VIACS = 1;
        #1;
        totalCnt++;
        if (SlowReq !== 1'b0) $display("FAIL via_pre_start: got req=%b want 0", SlowReq);
        else passCnt++;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b1 || SlowGateReq !== 1'b1)
            $display("FAIL via_start: got req=%b gate=%b want 1/1", SlowReq, SlowGateReq);
        else passCnt++;
        clk1(); clk1(); clk1();
        totalCnt++;
        if (SlowReq !== 1'b1 || SlowCnt !== 4'd0)
            $display("FAIL via_active: got req=%b cnt=%0d want 1/0", SlowReq, SlowCnt);
        else passCnt++;
        bus.BACT = 0; bus.VIACS = 0;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b1 || SlowCnt !== 4'd3)
            $display("FAIL via_hold: got req=%b cnt=%0d want 1/3", SlowReq, SlowCnt);
        else passCnt++;
        Tick = 1; clk1();
        Tick = 0; clk1();
        totalCnt++;
        if (SlowCnt !== 4'd2) $display("FAIL via_tick1: got cnt=%0d want 2", SlowCnt);
        else passCnt++;
        Tick = 1; clk1();
        totalCnt++;
        if (SlowCnt !== 4'd1 || SlowReq !== 1'b1)
            $display("FAIL via_tick2: got cnt=%0d req=%b want 1/1", SlowCnt, SlowReq);
        else passCnt++;
        clk1();
        Tick = 0;
        totalCnt++;
        if ({SlowReq, SlowGateReq, SlowCnt} !== 6'b0)
            $display("FAIL via_close: got req=%b gate=%b cnt=%0d want 0/0/0",
                     SlowReq, SlowGateReq, SlowCnt);
        else passCnt++;
        SlowVIA = 0;
        clk1();
    endtask

    task automatic test_disabled();
        SlowSCC = 0;
        bus.BACT = 1; bus.SCCCS = 1;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b0) $display("FAIL scc_disabled_1: got req=%b want 0", SlowReq);
        else passCnt++;
        clk1();
        bus.BACT = 0; bus.SCCCS = 0;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b0 || SlowCnt !== 4'd0)
            $display("FAIL scc_disabled_2: got req=%b cnt=%0d want 0/0", SlowReq, SlowCnt);
        else passCnt++;
    endtask

    task automatic test_timeout_zero();
        SlowIWM = 1; SlowTimeout = 4'd0; SlowClockGate = 0;
        bus.BACT = 1; bus.IWMCS = 1;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b1 || SlowGateReq !== 1'b0)
            $display("FAIL iwm_start: got req=%b gate=%b want 1/0", SlowReq, SlowGateReq);
        else passCnt++;
        bus.BACT = 0; bus.IWMCS = 0;
        clk1();
        totalCnt++;
        if (SlowReq !== 1'b0 || SlowCnt !== 4'd0)
            $display("FAIL iwm_to0_close: got req=%b cnt=%0d want 0/0", SlowReq, SlowCnt);
        else passCnt++;
        SlowIWM = 0;
        clk1();
    endtask

    task automatic test_collision();
        SlowSCSI = 1; SlowTimeout = 4'd3; SlowClockGate = 1;
        bus.BACT = 1; bus.SCSICS = 1;
        clk1();
        bus.BACT = 0; bus.SCSICS = 0;
        clk1();
        Tick = 1; clk1();
        Tick = 0;
        totalCnt++;
        if (SlowCnt !== 4'd2) $display("FAIL coll_setup: got cnt=%0d want 2", SlowCnt);
        else passCnt++;
        // Qualifying Start together with a Tick.
        bus.BACT = 1; bus.SCSICS = 1; Tick = 1;
        clk1();
        Tick = 0;
        totalCnt++;
        if (SlowCnt !== 4'd2 || SlowReq !== 1'b1)
            $display("FAIL coll_reenter: got cnt=%0d req=%b want 2/1", SlowCnt, SlowReq);
        else passCnt++;
        // Ticks while ACTIVE must not touch the count.
        Tick = 1; clk1();
        Tick = 0;
        totalCnt++;
        if (SlowCnt !== 4'd2) $display("FAIL coll_active_tick: got cnt=%0d want 2", SlowCnt);
        else passCnt++;
        SlowTimeout = 4'd5;
        bus.BACT = 0; bus.SCSICS = 0;
        clk1();
        totalCnt++;
        if (SlowCnt !== 4'd5 || SlowReq !== 1'b1)
            $display("FAIL coll_reload: got cnt=%0d req=%b want 5/1", SlowCnt, SlowReq);
        else passCnt++;
        // Non-qualifying access in HOLD: countdown continues.
        SlowTimeout = 4'd9;
        bus.BACT = 1; bus.SCCCS = 1; Tick = 1;
        clk1();
        bus.BACT = 0; bus.SCCCS = 0; Tick = 0;
        totalCnt++;
        if (SlowCnt !== 4'd4 || SlowReq !== 1'b1)
            $display("FAIL hold_nonqual: got cnt=%0d req=%b want 4/1", SlowCnt, SlowReq);
        else passCnt++;
        Tick = 1;
        for (int i = 0; i < 3; i++) clk1();
        totalCnt++;
        if (SlowCnt !== 4'd1 || SlowReq !== 1'b1)
            $display("FAIL coll_drain: got cnt=%0d req=%b want 1/1", SlowCnt, SlowReq);
        else passCnt++;
        clk1();
        Tick = 0;
        totalCnt++;
        if (SlowReq !== 1'b0 || SlowCnt !== 4'd0)
            $display("FAIL coll_close: got req=%b cnt=%0d want 0/0", SlowReq, SlowCnt);
        else passCnt++;
        // No wrap on an extra tick in IDLE.
        Tick = 1; clk1(); Tick = 0;
        totalCnt++;
        if (SlowCnt !== 4'd0) $display("FAIL no_wrap: got cnt=%0d want 0", SlowCnt);
        else passCnt++;
        SlowSCSI = 0;
    endtask

    task automatic test_reset_mid();
        SlowVIA = 1; SlowTimeout = 4'd3; SlowClockGate = 1;
        bus.BACT = 1; bus.VIACS = 1;
        clk1();
        bus.BACT = 0; bus.VIACS = 0;
        clk1();
        totalCnt++;
        if (SlowCnt !== 4'd3 || SlowGateReq !== 1'b1)
            $display("FAIL rst_setup: got cnt=%0d gate=%b want 3/1", SlowCnt, SlowGateReq);
        else passCnt++;
        #2;
        nPOR = 0;
        #1;
        totalCnt++;
        if ({SlowReq, SlowGateReq, SlowCnt} !== 6'b0)
            $display("FAIL rst_async: got req=%b gate=%b cnt=%0d want 0/0/0",
                     SlowReq, SlowGateReq, SlowCnt);
        else passCnt++;
        #1;
        nPOR = 1;
        Tick = 1;
        clk1();
        Tick = 0;
        totalCnt++;
        if (SlowReq !== 1'b0 || SlowCnt !== 4'd0)
            $display("FAIL rst_after: got req=%b cnt=%0d want 0/0", SlowReq, SlowCnt);
        else passCnt++;
        SlowVIA = 0;
    endtask

`ifdef SLOW_WINDOW_DBG_EN
    task automatic openWindow();
        bus.BACT = 1; bus.SndCS = 1;
        clk1();
        bus.BACT = 0; bus.SndCS = 0;
        clk1();
    endtask

    task automatic test_dbg();
        nPOR = 0; #1; nPOR = 1;
        clk1();
        SlowSnd = 1; SlowTimeout = 4'd2;
        openWindow();
        // Re-entry from HOLD: not counted.
        openWindow();
        Tick = 1; clk1(); clk1(); Tick = 0;
        openWindow();
        Tick = 1; clk1(); clk1(); Tick = 0;
        openWindow();
        Tick = 1; clk1(); clk1(); Tick = 0;
        totalCnt++;
        if (SlowWinCnt !== 16'd3) $display("FAIL dbg_count: got %0d want 3", SlowWinCnt);
        else passCnt++;
        force dut.SlowWinCnt = 16'hFFFE;
        #1;
        release dut.SlowWinCnt;
        openWindow();
        Tick = 1; clk1(); clk1(); Tick = 0;
        openWindow();
        Tick = 1; clk1(); clk1(); Tick = 0;
        totalCnt++;
        if (SlowWinCnt !== 16'hFFFF) $display("FAIL dbg_sat: got %h want ffff", SlowWinCnt);
        else passCnt++;
        SlowSnd = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_via();
        test_disabled();
        test_timeout_zero();
        test_collision();
        test_reset_mid();
`ifdef SLOW_WINDOW_DBG_EN
        test_dbg();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
